// File: rtl/hls_macc_arb.sv
// hls_macc_arb: round-robin arbiter that shares one hls_macc core among
// N_REQ requesters. One transaction at a time: grant, start the core, wait
// for ap_done (or time out), publish the captured result, return to idle.
//
// Ports
//   ap_clk        clock, all state changes on the rising edge
//   ap_rst_n      asynchronous active-low reset
//   req           per-requester level request
//   gnt           one-hot grant, held for the whole transaction
//   sel           index of the granted requester (external operand mux)
//   core_start    core ap_start, high while in RUN
//   core_done     core ap_done, only looked at while in RUN
//   core_out1..3, core_return   core result buses
//   res_out1..3,  res_return    captured results, stable until next capture
//   res_vld       one-cycle result strobe
//   res_id        requester index owning the result (valid with res_vld)
//   busy          high whenever the FSM is not idle
//   err_timeout   one-cycle abort strobe
//   txn_cnt       count of completed transactions, wraps at 16 bits
module hls_macc_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16,
    localparam int SEL_W  = $clog2(N_REQ)
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              core_start,
    input  logic              core_done,
    input  logic [31:0]       core_out1,
    input  logic [31:0]       core_out2,
    input  logic [31:0]       core_out3,
    input  logic [31:0]       core_return,
    output logic [31:0]       res_out1,
    output logic [31:0]       res_out2,
    output logic [31:0]       res_out3,
    output logic [31:0]       res_return,
    output logic              res_vld,
    output logic [SEL_W-1:0]  res_id,
    output logic              busy,
    output logic              err_timeout,
    output logic [15:0]       txn_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

    state_t            state, state_nxt;
    logic [7:0]        run_cnt;
    logic [SEL_W-1:0]  last;
    logic [SEL_W-1:0]  winner;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_found;
    logic              run_expired;

    // Counter reaches TIMEOUT on this RUN cycle's increment.
    assign run_expired = (run_cnt == 8'(TIMEOUT - 1));

    // Round-robin search: first requester at or after last+1, wrapping.
    always_comb begin
        winner   = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_idx = SEL_W'((int'(last) + k) % N_REQ);
            if (!rr_found && req[rr_idx]) begin
                winner   = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded strobes; core_start depends only on the
    // state register so there is no combinational path from core_done.
    always_comb begin
        state_nxt   = state;
        core_start  = 1'b0;
        res_vld     = 1'b0;
        res_id      = '0;
        err_timeout = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req) state_nxt = RUN;
            end
            RUN: begin
                core_start = 1'b1;
                // core_done wins over an expiring counter
                if (core_done)        state_nxt = DONE;
                else if (run_expired) state_nxt = ABORT;
            end
            DONE: begin
                res_vld   = 1'b1;
                res_id    = sel;
                state_nxt = IDLE;
            end
            ABORT: begin
                err_timeout = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            gnt        <= '0;
            sel        <= '0;
            last       <= SEL_W'(N_REQ - 1);
            run_cnt    <= '0;
            res_out1   <= '0;
            res_out2   <= '0;
            res_out3   <= '0;
            res_return <= '0;
            txn_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt     <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                        sel     <= winner;
                        last    <= winner;
                        run_cnt <= '0;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        res_out1   <= core_out1;
                        res_out2   <= core_out2;
                        res_out3   <= core_out3;
                        res_return <= core_return;
                    end else begin
                        run_cnt <= run_cnt + 8'd1;
                    end
                end
                DONE: begin
                    gnt     <= '0;
                    txn_cnt <= txn_cnt + 16'd1;
                end
                ABORT: begin
                    gnt <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hls_macc_arb.sv
module tb_hls_macc_arb;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        core_start;
    logic        core_done;
    logic [31:0] core_out1, core_out2, core_out3, core_return;
    logic [31:0] res_out1, res_out2, res_out3, res_return;
    logic        res_vld;
    logic [1:0]  res_id;
    logic        busy;
    logic        err_timeout;
    logic [15:0] txn_cnt;

    int total = 0;
    int bad   = 0;

    hls_macc_arb #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req(req), .gnt(gnt), .sel(sel),
        .core_start(core_start), .core_done(core_done),
        .core_out1(core_out1), .core_out2(core_out2), .core_out3(core_out3),
        .core_return(core_return),
        .res_out1(res_out1), .res_out2(res_out2), .res_out3(res_out3),
        .res_return(res_return), .res_vld(res_vld), .res_id(res_id),
        .busy(busy), .err_timeout(err_timeout), .txn_cnt(txn_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    // Core model: ap_done comes core_lat cycles after ap_start first rises.
    int          core_lat  = NEVER;
    logic [31:0] core_base = '0;
    int          run_cyc   = 0;
    logic        inject    = 1'b0;

    always @(posedge ap_clk) begin
        if (core_start) run_cyc <= run_cyc + 1;
        else            run_cyc <= 0;
    end

    always_comb begin
        core_done = inject;
        if (core_start && run_cyc == core_lat) core_done = 1'b1;
    end

    assign core_out1   = core_base + 32'd1;
    assign core_out2   = core_base + 32'd2;
    assign core_out3   = core_base + 32'd3;
    assign core_return = core_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One transaction starting from IDLE. Expected values come from the caller.
    task automatic run_txn(input logic [3:0] r, input int lat, input logic [31:0] base,
                           input bit hold, input logic [3:0] egnt, input logic [1:0] esel,
                           input bit edone, input int ecyc, input logic [31:0] eret,
                           input logic [15:0] ecnt);
        int k;
        bit fin;
        k = 0;
        while (busy !== 1'b0 && k < 50) begin
            @(negedge ap_clk);
            k++;
        end
        chk("idle_before", busy, 0);
        core_lat  = lat;
        core_base = base;
        req       = r;
        @(negedge ap_clk);
        chk("gnt", gnt, egnt);
        chk("sel", sel, esel);
        chk("core_start", core_start, 1);
        if (!hold) req = '0;
        k = 1;
        fin = 0;
        while (!fin && k < 40) begin
            if (res_vld === 1'b1 || err_timeout === 1'b1) fin = 1;
            else begin
                @(negedge ap_clk);
                k++;
            end
        end
        chk("term_cycle", k, ecyc);
        chk("res_vld", res_vld, edone);
        chk("err_timeout", err_timeout, !edone);
        chk("gnt_held", gnt, egnt);
        chk("res_return", res_return, eret);
        if (edone) begin
            chk("res_id", res_id, esel);
            chk("res_out1", res_out1, eret + 32'd1);
            chk("res_out3", res_out3, eret + 32'd3);
        end
        @(negedge ap_clk);
        chk("busy_after", busy, 0);
        chk("gnt_after", gnt, 0);
        chk("res_vld_after", res_vld, 0);
        chk("txn_cnt", txn_cnt, ecnt);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        req = '0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    // Reference model state
    int          m_last;
    int          m_cnt;
    logic [31:0] m_ret;

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= N_REQ; k++)
            if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
        return -1;
    endfunction

    task automatic model_txn(input logic [3:0] r, input int lat, input logic [31:0] base);
        int w;
        bit done;
        w = rr_pick(r, m_last);
        done = (lat <= TIMEOUT - 1);
        m_last = w;
        if (done) begin
            m_cnt = (m_cnt + 1) % 65536;
            m_ret = base;
        end
        run_txn(r, lat, base, 1'b0, 4'(1 << w), 2'(w), done,
                done ? lat + 2 : TIMEOUT + 1, m_ret, 16'(m_cnt));
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] r;
        int         lat;
        logic [3:0] egnt;
        logic [1:0] esel;
        bit         edone;
        int         ecyc;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] base;
        logic [31:0] ret_m;

        vecs[0]  = '{1, 4'b0100, 4,     4'b0100, 2'd2, 1, 6,  16'd1};
        vecs[1]  = '{1, 4'b1111, 4,     4'b0001, 2'd0, 1, 6,  16'd1};
        vecs[2]  = '{0, 4'b1111, 4,     4'b0010, 2'd1, 1, 6,  16'd2};
        vecs[3]  = '{0, 4'b1111, 4,     4'b0100, 2'd2, 1, 6,  16'd3};
        vecs[4]  = '{0, 4'b1111, 4,     4'b1000, 2'd3, 1, 6,  16'd4};
        vecs[5]  = '{0, 4'b1111, 4,     4'b0001, 2'd0, 1, 6,  16'd5};
        vecs[6]  = '{0, 4'b1111, 4,     4'b0010, 2'd1, 1, 6,  16'd6};
        vecs[7]  = '{0, 4'b1111, 4,     4'b0100, 2'd2, 1, 6,  16'd7};
        vecs[8]  = '{0, 4'b1111, 4,     4'b1000, 2'd3, 1, 6,  16'd8};
        vecs[9]  = '{0, 4'b1111, NEVER, 4'b0001, 2'd0, 0, 17, 16'd8};
        vecs[10] = '{0, 4'b1111, 4,     4'b0010, 2'd1, 1, 6,  16'd9};
        vecs[11] = '{0, 4'b0010, 15,    4'b0010, 2'd1, 1, 17, 16'd10};
        vecs[12] = '{0, 4'b1000, 0,     4'b1000, 2'd3, 1, 2,  16'd11};
        vecs[13] = '{0, 4'b0011, 16,    4'b0001, 2'd0, 0, 17, 16'd11};

        // Reset state
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_res_return", res_return, 0);
        chk("rst_res_vld", res_vld, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn_cnt", txn_cnt, 0);

        ret_m = '0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) begin
                do_reset();
                ret_m = '0;
            end
            base = (i == 0) ? 32'h12345678 : 32'hA000_0000 + 32'(i) * 32'h1111;
            if (vecs[i].edone) ret_m = base;
            run_txn(vecs[i].r, vecs[i].lat, base, vecs[i].r == 4'b1111,
                    vecs[i].egnt, vecs[i].esel, vecs[i].edone, vecs[i].ecyc,
                    ret_m, vecs[i].ecnt);
        end

        // core_done outside RUN is ignored
        req = '0;
        @(negedge ap_clk);
        inject = 1'b1;
        @(negedge ap_clk);
        chk("inject_busy", busy, 0);
        chk("inject_vld", res_vld, 0);
        inject = 1'b0;
        @(negedge ap_clk);
        chk("inject_cnt", txn_cnt, 16'd11);

        // Reset in the middle of RUN
        core_lat = NEVER;
        req = 4'b0010;
        repeat (4) @(negedge ap_clk);
        chk("pre_rst_start", core_start, 1);
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        chk("midrst_start", core_start, 0);
        chk("midrst_gnt", gnt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_vld", res_vld, 0);
        chk("midrst_cnt", txn_cnt, 0);
        req = '0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_txn(4'b1001, 4, 32'hCAFE0001, 1'b0, 4'b0001, 2'd0, 1, 6, 32'hCAFE0001, 16'd1);

        // Randomized phase against the reference model
        m_last = 0;
        m_cnt  = 1;
        m_ret  = 32'hCAFE0001;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] r;
            int lat;
            int pick;
            r = 4'($urandom_range(1, 15));
            pick = $urandom_range(0, 9);
            if (pick < 7)       lat = $urandom_range(0, 14);
            else if (pick == 7) lat = 15;
            else if (pick == 8) lat = 16;
            else                lat = NEVER;
            model_txn(r, lat, $urandom);
        end

        // txn_cnt wrap
        @(negedge ap_clk);
        force dut.txn_cnt = 16'hFFFF;
        @(negedge ap_clk);
        release dut.txn_cnt;
        m_cnt = 65535;
        model_txn(4'b0100, 3, 32'h0BAD_F00D);
        chk("wrap_zero", txn_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
